sound_sequencer: RTL and testbench

//  Arbitrates the game's sound-effect requests (button press, point scored, win, start chime)
//  and sequences the winning effect as timed notes. Drives half-period and enable to the

---
 rtl/sound_sequencer.sv | 161 ++++++++++++++++
 tb/tb_sound_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// sound_sequencer: arbitrates game sound-effect requests and plays the winning effect as timed
// notes for the square-wave tone generator. Define SOUND_PENDING_EN to add a one-entry slot that
// replays the best request dropped while an effect was busy.
module sound_sequencer #(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_CYC = CLK_HZ / 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic        sound_en,
    output logic [18:0] half_period,
    output logic        tone_en,
    output logic        busy,
    output logic [1:0]  cur_id,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    localparam logic [18:0] HP_A4 = 19'(CLK_HZ / 880);
    localparam logic [18:0] HP_C5 = 19'(CLK_HZ / 1046);
    localparam logic [18:0] HP_E5 = 19'(CLK_HZ / 1318);
    localparam logic [18:0] HP_G5 = 19'(CLK_HZ / 1568);
    localparam logic [18:0] HP_A5 = 19'(CLK_HZ / 1760);
    localparam logic [18:0] HP_C6 = 19'(CLK_HZ / 2094);
    localparam logic [16:0] PRE_MAX = 17'(TICK_CYC - 1);

    localparam logic [2:0] N_A4 = 3'd0, N_C5 = 3'd1, N_E5 = 3'd2, N_G5 = 3'd3;
    localparam logic [2:0] N_A5 = 3'd4, N_C6 = 3'd5, N_REST = 3'd7;

    function automatic logic [2:0] note_of(input logic [1:0] id, input logic [1:0] i);
        case (id)
            2'd0:    note_of = N_A5;
            2'd1:    note_of = (i == 2'd0) ? N_C5 : N_E5;
            2'd2:    note_of = (i == 2'd0) ? N_C5 : (i == 2'd1) ? N_E5 : (i == 2'd2) ? N_G5 : N_C6;
            default: note_of = (i == 2'd1) ? N_REST : N_A4;
        endcase
    endfunction

    function automatic logic [7:0] dur_of(input logic [1:0] id, input logic [1:0] i);
        dur_of = (id == 2'd0) ? 8'd50 : (id == 2'd1) ? 8'd100 : (id == 2'd2) ? 8'd150 :
                 (i == 2'd1) ? 8'd100 : 8'd200;
    endfunction

    function automatic logic [1:0] last_of(input logic [1:0] id);
        last_of = (id == 2'd0) ? 2'd0 : (id == 2'd1) ? 2'd1 : (id == 2'd2) ? 2'd3 : 2'd2;
    endfunction

    function automatic logic [18:0] hp_of(input logic [2:0] n);
        case (n)
            N_A4:    hp_of = HP_A4;
            N_C5:    hp_of = HP_C5;
            N_E5:    hp_of = HP_E5;
            N_G5:    hp_of = HP_G5;
            N_A5:    hp_of = HP_A5;
            N_C6:    hp_of = HP_C6;
            default: hp_of = 19'd0;
        endcase
    endfunction

    // WIN > SCORE > PRESS > START
    function automatic logic [1:0] prio(input logic [1:0] id);
        prio = (id == 2'd2) ? 2'd3 : (id == 2'd1) ? 2'd2 : (id == 2'd0) ? 2'd1 : 2'd0;
    endfunction

    state_t      state;
    logic [1:0]  idx;
    logic [16:0] presc;
    logic [7:0]  ticks;
    logic        req_v, preempt, start_v, tick_end, note_end;
    logic [1:0]  req_id, start_id, next_idx, pend_id;
    logic [2:0]  start_note, next_note;
    logic        pend_v;

    assign req_v      = |req;
    assign req_id     = req[2] ? 2'd2 : req[1] ? 2'd1 : req[0] ? 2'd0 : 2'd3;
    assign preempt    = req_v && (prio(req_id) > prio(cur_id));
    assign start_v    = (state == IDLE && req_v) || (state == PLAY && preempt) ||
                        (state == DONE && (req_v || pend_v));
    assign start_id   = (state == DONE && !req_v) ? pend_id : req_id;
    assign start_note = note_of(start_id, 2'd0);
    assign next_idx   = idx + 2'd1;
    assign next_note  = note_of(cur_id, next_idx);
    assign tick_end   = presc == PRE_MAX;
    assign note_end   = tick_end && (ticks == dur_of(cur_id, idx) - 8'd1);

    // Sequencer: start/preempt effects, time each note, step through the table, pulse done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            presc       <= '0;
            ticks       <= '0;
            half_period <= '0;
            tone_en     <= 1'b0;
            busy        <= 1'b0;
            cur_id      <= '0;
            done        <= 1'b0;
        end else if (!sound_en) begin
            state       <= IDLE;
            idx         <= '0;
            presc       <= '0;
            ticks       <= '0;
            half_period <= '0;
            tone_en     <= 1'b0;
            busy        <= 1'b0;
            cur_id      <= '0;
            done        <= 1'b0;
        end else if (start_v) begin
            state       <= PLAY;
            cur_id      <= start_id;
            idx         <= '0;
            presc       <= '0;
            ticks       <= '0;
            half_period <= hp_of(start_note);
            tone_en     <= start_note != N_REST;
            busy        <= 1'b1;
            done        <= 1'b0;
        end else if (state == PLAY) begin
            presc <= tick_end ? '0 : presc + 17'd1;
            ticks <= note_end ? '0 : tick_end ? ticks + 8'd1 : ticks;
            if (note_end && idx == last_of(cur_id)) begin
                state       <= DONE;
                half_period <= '0;
                tone_en     <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b1;
            end else if (note_end) begin
                idx         <= next_idx;
                half_period <= hp_of(next_note);
                tone_en     <= next_note != N_REST;
            end
        end else begin
            state <= IDLE;
            done  <= 1'b0;
        end
    end

`ifdef SOUND_PENDING_EN
    logic drop;
    assign drop = (state == PLAY) && req_v && !preempt;

    // Pending slot keeps the best dropped request until the DONE cycle replays it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_v  <= 1'b0;
            pend_id <= '0;
        end else if (!sound_en || (state == DONE && !req_v)) begin
            pend_v  <= 1'b0;
            pend_id <= '0;
        end else if (drop && (!pend_v || prio(req_id) > prio(pend_id))) begin
            pend_v  <= 1'b1;
            pend_id <= req_id;
        end
    end
`else
    assign pend_v  = 1'b0;
    assign pend_id = 2'd0;
`endif

endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: directed requests push hand-computed output events (cycle + values) into a
// scoreboard; a monitor pops one entry on every output change and compares it.
module tb_sound_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sound_en = 1'b1;
    logic [3:0]  req = 4'd0;
    logic [18:0] half_period;
    logic        tone_en, busy, done;
    logic [1:0]  cur_id;

    sound_sequencer #(.CLK_HZ(100_000_000), .TICK_CYC(10)) dut (
        .clk(clk), .rst(rst), .req(req), .sound_en(sound_en),
        .half_period(half_period), .tone_en(tone_en), .busy(busy),
        .cur_id(cur_id), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [18:0] hp;
        logic        en;
        logic        bz;
        logic [1:0]  id;
        logic        dn;
    } ev_t;

    ev_t         sb[$];
    ev_t         e;
    int          errors = 0;
    int          checks = 0;
    bit          mon_on = 1'b0;
    logic [23:0] prev, now_v;

    task automatic expect_ev(input int c, input logic [18:0] hp, input logic en, input logic bz,
                             input logic [1:0] id, input logic dn);
        sb.push_back('{c, hp, en, bz, id, dn});
    endtask

    // Drive a one-cycle request at the negedge where cyc == c (c must be in the future)
    task automatic drive_at(input int c, input logic [3:0] r);
        do @(negedge clk); while (cyc < c);
        req = r;
        @(negedge clk);
        req = 4'd0;
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d events outstanding after %0d cycles, required 0", sb.size(), lim);
            sb.delete();
        end
        repeat (20) @(negedge clk);
    endtask

    // Monitor: every change of the output vector must match the next expected event
    always @(negedge clk) begin
        if (mon_on) begin
            now_v = {half_period, tone_en, busy, cur_id, done};
            if (now_v !== prev) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected at cyc %0d: got hp=%0d en=%0b busy=%0b id=%0d done=%0b, required no change",
                             cyc, half_period, tone_en, busy, cur_id, done);
                end else begin
                    e = sb.pop_front();
                    if (now_v !== {e.hp, e.en, e.bz, e.id, e.dn} || cyc != e.c) begin
                        errors++;
                        $display("FAIL event at cyc %0d: got hp=%0d en=%0b busy=%0b id=%0d done=%0b, required cyc %0d hp=%0d en=%0b busy=%0b id=%0d done=%0b",
                                 cyc, half_period, tone_en, busy, cur_id, done,
                                 e.c, e.hp, e.en, e.bz, e.id, e.dn);
                    end
                end
                prev = now_v;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, s;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({half_period, tone_en, busy, cur_id, done} !== 24'd0) begin
            errors++;
            $display("FAIL reset: got %h, required 0", {half_period, tone_en, busy, cur_id, done});
        end
        prev = 24'd0;
        mon_on = 1'b1;
        rst = 1'b1;

        // PRESS alone: A5 for 500 cycles, then done pulse
        t = cyc + 2;
        expect_ev(t + 1, 19'd56818, 1, 1, 2'd0, 0);
        expect_ev(t + 501, 19'd0, 0, 0, 2'd0, 1);
        expect_ev(t + 502, 19'd0, 0, 0, 2'd0, 0);
        drive_at(t, 4'b0001);
        drain(700);

        // START+PRESS together: PRESS outranks START
        t = cyc + 2;
        expect_ev(t + 1, 19'd56818, 1, 1, 2'd0, 0);
        expect_ev(t + 501, 19'd0, 0, 0, 2'd0, 1);
        expect_ev(t + 502, 19'd0, 0, 0, 2'd0, 0);
        drive_at(t, 4'b1001);
        drain(700);

        // SCORE+WIN together: WIN plays all four notes
        t = cyc + 2;
        expect_ev(t + 1, 19'd95602, 1, 1, 2'd2, 0);
        expect_ev(t + 1501, 19'd75872, 1, 1, 2'd2, 0);
        expect_ev(t + 3001, 19'd63775, 1, 1, 2'd2, 0);
        expect_ev(t + 4501, 19'd47755, 1, 1, 2'd2, 0);
        expect_ev(t + 6001, 19'd0, 0, 0, 2'd2, 1);
        expect_ev(t + 6002, 19'd0, 0, 0, 2'd2, 0);
        drive_at(t, 4'b0110);
        drain(6500);

        // START preempted by SCORE 50 cycles in; no done for START
        t = cyc + 2;
        s = t + 50;
        expect_ev(t + 1, 19'd113636, 1, 1, 2'd3, 0);
        expect_ev(s + 1, 19'd95602, 1, 1, 2'd1, 0);
        expect_ev(s + 1001, 19'd75872, 1, 1, 2'd1, 0);
        expect_ev(s + 2001, 19'd0, 0, 0, 2'd1, 1);
        expect_ev(s + 2002, 19'd0, 0, 0, 2'd1, 0);
        drive_at(t, 4'b1000);
        drive_at(s, 4'b0010);
        drain(2500);

        // WIN playing, lower-priority PRESS dropped (or pended)
        t = cyc + 2;
        expect_ev(t + 1, 19'd95602, 1, 1, 2'd2, 0);
        expect_ev(t + 1501, 19'd75872, 1, 1, 2'd2, 0);
        expect_ev(t + 3001, 19'd63775, 1, 1, 2'd2, 0);
        expect_ev(t + 4501, 19'd47755, 1, 1, 2'd2, 0);
        expect_ev(t + 6001, 19'd0, 0, 0, 2'd2, 1);
`ifdef SOUND_PENDING_EN
        expect_ev(t + 6002, 19'd56818, 1, 1, 2'd0, 0);
        expect_ev(t + 6502, 19'd0, 0, 0, 2'd0, 1);
        expect_ev(t + 6503, 19'd0, 0, 0, 2'd0, 0);
`else
        expect_ev(t + 6002, 19'd0, 0, 0, 2'd2, 0);
`endif
        drive_at(t, 4'b0100);
        drive_at(t + 10, 4'b0001);
        drain(7000);

        // Request on the DONE cycle starts the next effect without an idle cycle
        t = cyc + 2;
        expect_ev(t + 1, 19'd56818, 1, 1, 2'd0, 0);
        expect_ev(t + 501, 19'd0, 0, 0, 2'd0, 1);
        expect_ev(t + 502, 19'd95602, 1, 1, 2'd1, 0);
        expect_ev(t + 1502, 19'd75872, 1, 1, 2'd1, 0);
        expect_ev(t + 2502, 19'd0, 0, 0, 2'd1, 1);
        expect_ev(t + 2503, 19'd0, 0, 0, 2'd1, 0);
        drive_at(t, 4'b0001);
        drive_at(t + 501, 4'b0010);
        drain(3000);

        // START aborted by sound_en=0; START request during that cycle ignored
        t = cyc + 2;
        s = t + 30;
        expect_ev(t + 1, 19'd113636, 1, 1, 2'd3, 0);
        expect_ev(s + 1, 19'd0, 0, 0, 2'd0, 0);
        drive_at(t, 4'b1000);
        do @(negedge clk); while (cyc < s);
        sound_en = 1'b0;
        req = 4'b1000;
        @(negedge clk);
        sound_en = 1'b1;
        req = 4'd0;
        drain(100);

        // Async reset mid-SCORE clears outputs between edges and stays idle afterwards
        t = cyc + 2;
        expect_ev(t + 1, 19'd95602, 1, 1, 2'd1, 0);
        drive_at(t, 4'b0010);
        do @(negedge clk); while (cyc < t + 300);
        @(posedge clk);
        #2;
        expect_ev(cyc, 19'd0, 0, 0, 2'd0, 0);
        rst = 1'b0;
        #1;
        checks++;
        if ({half_period, tone_en, busy, cur_id, done} !== 24'd0) begin
            errors++;
            $display("FAIL async_reset: got %h, required 0", {half_period, tone_en, busy, cur_id, done});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (50) @(negedge clk);
        t = cyc + 2;
        expect_ev(t + 1, 19'd56818, 1, 1, 2'd0, 0);
        expect_ev(t + 501, 19'd0, 0, 0, 2'd0, 1);
        expect_ev(t + 502, 19'd0, 0, 0, 2'd0, 0);
        drive_at(t, 4'b0001);
        drain(700);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
